preg_freelist: RTL and testbench

Physical-register free list for the rename/dispatch stage. Supplies up to two free pregs per cycle for instr0/instr1 destinations; these are the same prd values dispatch writes into the busy table's alloc ports. Commit returns old pregs to the list. A committed (architectural) head pointer lets the list restore on flush and re-advance during ROB walk, matching the busy-table rollback/walk sequence.

---
 rtl/preg_freelist.sv | 170 +++++++++++++++++
 tb/tb_preg_freelist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_freelist.sv
//==============================================================================
// Module   : preg_freelist
// Purpose  : Physical-register free list, 2 alloc / 2 commit per cycle, with
//            flush restore to the committed head and ROB-walk re-advance.
// Options  : define PREG_FREELIST_CHECK_EN to add the sticky fl_err output.
// Revision : 1.0
//==============================================================================
`default_nettype none

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module preg_freelist #(
    parameter int PREG_SIZE = 64,
    parameter int ARCH_REGS = 32,
    parameter int DEPTH     = PREG_SIZE - ARCH_REGS,
    parameter int PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         disp2fl_instr0_req,
    input  logic                         disp2fl_instr1_req,
    output logic                         fl2disp_ready,
    output logic [$clog2(PREG_SIZE)-1:0] fl2disp_instr0_prd,
    output logic [$clog2(PREG_SIZE)-1:0] fl2disp_instr1_prd,
    input  logic                         rob_commit0_rd_en,
    input  logic [$clog2(PREG_SIZE)-1:0] rob_commit0_old_prd,
    input  logic                         rob_commit1_rd_en,
    input  logic [$clog2(PREG_SIZE)-1:0] rob_commit1_old_prd,
    input  logic                         flush_valid,
    input  logic [1:0]                   rob_state,
    input  logic                         rob_walk0_valid,
    input  logic                         rob_walk1_valid,
    output logic [PTR_W-1:0]             fl_free_count
`ifdef PREG_FREELIST_CHECK_EN
    ,
    output logic                         fl_err
`endif
);

    localparam int c_IDX_W  = PTR_W - 1;
    localparam int c_PREG_W = $clog2(PREG_SIZE);

    logic [c_PREG_W-1:0] r_fl_mem [DEPTH];
    logic [PTR_W-1:0]    r_spec_head;
    logic [PTR_W-1:0]    r_arch_head;
    logic [PTR_W-1:0]    r_tail;

    logic [PTR_W-1:0]    w_free_count;
    logic                w_ready;
    logic                w_alloc_fire;
    logic [PTR_W-1:0]    w_alloc_cnt;
    logic [PTR_W-1:0]    w_commit_cnt;
    logic [PTR_W-1:0]    w_walk_cnt;
    logic [PTR_W-1:0]    w_head1_ptr;
    logic [PTR_W-1:0]    w_tail1_ptr;
    logic [PTR_W-1:0]    w_spec_head_nxt;
    logic [PTR_W-1:0]    w_arch_head_nxt;
    logic [PTR_W-1:0]    w_tail_nxt;

    always_comb begin
        w_free_count    = r_tail - r_spec_head;
        w_ready         = (w_free_count >= PTR_W'(2)) &&
                          (rob_state == `ROB_STATE_IDLE) && !flush_valid;
        w_alloc_fire    = w_ready && (disp2fl_instr0_req || disp2fl_instr1_req);
        w_alloc_cnt     = PTR_W'(disp2fl_instr0_req) + PTR_W'(disp2fl_instr1_req);
        w_commit_cnt    = PTR_W'(rob_commit0_rd_en) + PTR_W'(rob_commit1_rd_en);
        w_walk_cnt      = PTR_W'(rob_walk0_valid) + PTR_W'(rob_walk1_valid);
        // instr1 alone takes the head entry
        w_head1_ptr     = r_spec_head + PTR_W'(disp2fl_instr0_req);
        w_tail1_ptr     = r_tail + PTR_W'(rob_commit0_rd_en);
        w_arch_head_nxt = r_arch_head + w_commit_cnt;
        w_tail_nxt      = r_tail + w_commit_cnt;

        w_spec_head_nxt = r_spec_head;
        if (flush_valid)
            w_spec_head_nxt = w_arch_head_nxt;
        else if (rob_state == `ROB_STATE_WALK)
            w_spec_head_nxt = r_spec_head + w_walk_cnt;
        else if (w_alloc_fire)
            w_spec_head_nxt = r_spec_head + w_alloc_cnt;
    end

    assign fl2disp_ready      = w_ready;
    assign fl_free_count      = w_free_count;
    assign fl2disp_instr0_prd = r_fl_mem[r_spec_head[c_IDX_W-1:0]];
    assign fl2disp_instr1_prd = r_fl_mem[w_head1_ptr[c_IDX_W-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_spec_head <= '0;
            r_arch_head <= '0;
            r_tail      <= {1'b1, {c_IDX_W{1'b0}}};
        end else begin
            r_spec_head <= w_spec_head_nxt;
            r_arch_head <= w_arch_head_nxt;
            r_tail      <= w_tail_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_fl_mem[i] <= c_PREG_W'(ARCH_REGS + i);
        end else begin
            if (rob_commit0_rd_en)
                r_fl_mem[r_tail[c_IDX_W-1:0]] <= rob_commit0_old_prd;
            if (rob_commit1_rd_en)
                r_fl_mem[w_tail1_ptr[c_IDX_W-1:0]] <= rob_commit1_old_prd;
        end
    end

`ifdef PREG_FREELIST_CHECK_EN
    logic [PREG_SIZE-1:0] r_in_list;
    logic [PREG_SIZE-1:0] w_in_list_nxt;
    logic                 r_fl_err;
    logic                 w_double_free;
    logic                 w_bad_count;
    logic [PTR_W-1:0]     w_walk1_ptr;
    logic [PTR_W-1:0]     w_count_nxt;

    always_comb begin
        w_walk1_ptr   = r_spec_head + PTR_W'(rob_walk0_valid);
        w_in_list_nxt = r_in_list;
        if (w_alloc_fire && disp2fl_instr0_req)
            w_in_list_nxt[fl2disp_instr0_prd] = 1'b0;
        if (w_alloc_fire && disp2fl_instr1_req)
            w_in_list_nxt[fl2disp_instr1_prd] = 1'b0;
        if (!flush_valid && rob_state == `ROB_STATE_WALK) begin
            if (rob_walk0_valid)
                w_in_list_nxt[r_fl_mem[r_spec_head[c_IDX_W-1:0]]] = 1'b0;
            if (rob_walk1_valid)
                w_in_list_nxt[r_fl_mem[w_walk1_ptr[c_IDX_W-1:0]]] = 1'b0;
        end
        w_double_free = (rob_commit0_rd_en && r_in_list[rob_commit0_old_prd]) ||
                        (rob_commit1_rd_en && (r_in_list[rob_commit1_old_prd] ||
                         (rob_commit0_rd_en && rob_commit0_old_prd == rob_commit1_old_prd)));
        if (rob_commit0_rd_en)
            w_in_list_nxt[rob_commit0_old_prd] = 1'b1;
        if (rob_commit1_rd_en)
            w_in_list_nxt[rob_commit1_old_prd] = 1'b1;
        // overflow and underflow both show up as an out-of-range free count
        w_count_nxt   = w_tail_nxt - w_spec_head_nxt;
        w_bad_count   = w_count_nxt > PTR_W'(DEPTH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_list <= {{DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};
            r_fl_err  <= 1'b0;
        end else begin
            r_in_list <= w_in_list_nxt;
            if (w_double_free || w_bad_count)
                r_fl_err <= 1'b1;
        end
    end

    assign fl_err = r_fl_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_preg_freelist.sv
//==============================================================================
// Module   : tb_preg_freelist
// Purpose  : Directed + random bench for preg_freelist against an integer model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_preg_freelist;

    localparam int PREG_SIZE = 64;
    localparam int ARCH_REGS = 32;
    localparam int DEPTH     = 32;
    localparam int PTR_W     = 6;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req0, req1;
    logic             ready;
    logic [5:0]       prd0, prd1;
    logic             c0_en, c1_en;
    logic [5:0]       c0_prd, c1_prd;
    logic             flush;
    logic [1:0]       rstate;
    logic             walk0, walk1;
    logic [PTR_W-1:0] free_count;
`ifdef PREG_FREELIST_CHECK_EN
    logic             fl_err;
`endif

    preg_freelist #(
        .PREG_SIZE(PREG_SIZE),
        .ARCH_REGS(ARCH_REGS)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .disp2fl_instr0_req (req0),
        .disp2fl_instr1_req (req1),
        .fl2disp_ready      (ready),
        .fl2disp_instr0_prd (prd0),
        .fl2disp_instr1_prd (prd1),
        .rob_commit0_rd_en  (c0_en),
        .rob_commit0_old_prd(c0_prd),
        .rob_commit1_rd_en  (c1_en),
        .rob_commit1_old_prd(c1_prd),
        .flush_valid        (flush),
        .rob_state          (rstate),
        .rob_walk0_valid    (walk0),
        .rob_walk1_valid    (walk1),
        .fl_free_count      (free_count)
`ifdef PREG_FREELIST_CHECK_EN
        ,
        .fl_err             (fl_err)
`endif
    );

    always #5 clock = ~clock;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string phase  = "init";

    // Reference model: unbounded integer pointers, entries indexed modulo DEPTH
    int m_mem [DEPTH];
    int m_spec, m_arch, m_tail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; c0_en = 0; c1_en = 0; c0_prd = 0; c1_prd = 0;
        flush = 0; rstate = 2'd0; walk0 = 0; walk1 = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = ARCH_REGS + i;
        m_spec = 0; m_arch = 0; m_tail = DEPTH;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        model_reset();
        #3;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // One cycle: drive at posedge+1, check at negedge, update model at posedge.
    task automatic step(input bit r0, input bit r1, input bit c0, input int p0,
                        input bit c1, input int p1, input bit fl, input int st,
                        input bit w0, input bit w1);
        bit ready_e;
        int arch_n;
        req0 = r0; req1 = r1; c0_en = c0; c0_prd = 6'(p0); c1_en = c1; c1_prd = 6'(p1);
        flush = fl; rstate = 2'(st); walk0 = w0; walk1 = w1;
        ready_e = ((m_tail - m_spec) >= 2) && (st == 0) && !fl;
        @(negedge clock);
        chk("ready", 32'(ready), 32'(ready_e));
        chk("prd0",  32'(prd0), 32'(m_mem[m_spec % DEPTH]));
        chk("prd1",  32'(prd1), 32'(m_mem[(m_spec + int'(r0)) % DEPTH]));
        chk("count", 32'(free_count), 32'(m_tail - m_spec));
        @(posedge clock);
        arch_n = m_arch + int'(c0) + int'(c1);
        if (c0) begin m_mem[m_tail % DEPTH] = p0; m_tail++; end
        if (c1) begin m_mem[m_tail % DEPTH] = p1; m_tail++; end
        if (fl)
            m_spec = arch_n;
        else if (st == 2)
            m_spec += int'(w0) + int'(w1);
        else if (ready_e && (r0 || r1))
            m_spec += int'(r0) + int'(r1);
        m_arch = arch_n;
        #1;
        drive_idle();
        #1;
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;

        phase = "reset";
        do_reset();
        chk("ready", 32'(ready), 32'd1);
        chk("prd0", 32'(prd0), 32'd32);
        chk("prd1", 32'(prd1), 32'd32);
        chk("count", 32'(free_count), 32'd32);

        phase = "dual";
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("count", 32'(free_count), 32'd30);
        chk("prd0", 32'(prd0), 32'd34);

        phase = "req1only";
        do_reset();
        req1 = 1; #1;
        chk("prd1", 32'(prd1), 32'd32);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("prd0", 32'(prd0), 32'd33);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        phase = "drain";
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("count", 32'(free_count), 32'd0);
        chk("ready", 32'(ready), 32'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 1, 9, 0, 0, 0, 0);
        chk("count", 32'(free_count), 32'd2);
        chk("ready", 32'(ready), 32'd1);
        req0 = 1; req1 = 1; #1;
        chk("prd0", 32'(prd0), 32'd5);
        chk("prd1", 32'(prd1), 32'd9);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        phase = "flushwalk";
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 2, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("count", 32'(free_count), 32'd32);
        chk("prd0", 32'(prd0), 32'd34);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        chk("count", 32'(free_count), 32'd28);
        chk("prd0", 32'(prd0), 32'd38);

        phase = "flushcommit";
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 7, 0, 0, 1, 0, 0, 0);
        chk("count", 32'(free_count), 32'd32);
        chk("prd0", 32'(prd0), 32'd33);

        phase = "midreset";
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("count", 32'(free_count), 32'd32);
        chk("prd0", 32'(prd0), 32'd32);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef PREG_FREELIST_CHECK_EN
        phase = "dblfree";
        do_reset();
        chk("err0", 32'(fl_err), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 40, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 40, 0, 0, 0, 0, 0, 0);
        chk("err1", 32'(fl_err), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("errsticky", 32'(fl_err), 32'd1);
        do_reset();
        chk("errclr", 32'(fl_err), 32'd0);
`endif

        phase = "random";
        do_reset();
        for (int it = 0; it < 400; it++) begin
            int sel, st, pend, room;
            bit r0, r1, c0, c1, fl, w0, w1;
            sel  = $urandom_range(0, 19);
            fl   = (sel == 0);
            st   = (sel inside {[1:2]}) ? 1 : (sel inside {[3:5]}) ? 2 : 0;
            r0   = 1'($urandom);
            r1   = 1'($urandom);
            pend = m_spec - m_arch;
            c0   = (pend >= 1) && ($urandom_range(0, 2) == 0);
            c1   = (pend >= (c0 ? 2 : 1)) && ($urandom_range(0, 2) == 0);
            room = m_tail - m_spec;
            w0   = (room >= 1) && 1'($urandom);
            w1   = (room >= (w0 ? 2 : 1)) && 1'($urandom);
            step(r0, r1, c0, int'($urandom_range(0, 63)), c1,
                 int'($urandom_range(0, 63)), fl, st, w0, w1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
